// File: rtl/axitrafficgen_rtl_pkg.sv
// Shared types and constants for the parametrised DMA traffic generator.
package axitrafficgen_rtl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_DATA,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_NOP  = 2'd0;
  localparam logic [1:0] MODE_RD   = 2'd1;
  localparam logic [1:0] MODE_WR   = 2'd2;
  localparam logic [1:0] MODE_RDWR = 2'd3;

  localparam logic [2:0] SIZE_32 = 3'b010;
  localparam logic [2:0] SIZE_64 = 3'b011;

  // conf_info_reg2 layout: mode in the low bits, iteration count from bit 8 up
  localparam int MODE_LSB = 0;
  localparam int MODE_W   = 2;
  localparam int ITER_LSB = 8;

  // DMA beat size encoding for a given channel width
  function automatic logic [2:0] dma_size(input int width);
    return (width == 64) ? SIZE_64 : SIZE_32;
  endfunction

endpackage

// File: rtl/axitrafficgen_rtl_pattern.sv
// Expected-word generator plus saturating read-mismatch counter.
// The same expected word feeds the read checker and the write data path.
module axitrafficgen_rtl_pattern #(
  parameter int DMA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 chk_en,
  input  logic [31:0]          base,
  input  logic [31:0]          w,
  input  logic [DMA_WIDTH-1:0] rd_data,
  output logic [DMA_WIDTH-1:0] exp_word,
  output logic [31:0]          mis_cnt
);

  logic [31:0] word;

  // pattern word is burst base plus beat offset, wrapping at 32 bits
  assign word     = base + w;
  assign exp_word = DMA_WIDTH'(word);

  // count mismatching read beats, sticking at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mis_cnt <= '0;
    else if (clear)
      mis_cnt <= '0;
    else if (chk_en && (rd_data != exp_word) && (mis_cnt != 32'hFFFF_FFFF))
      mis_cnt <= mis_cnt + 32'd1;
  end

endmodule

// File: rtl/axitrafficgen_rtl_dma_param.sv
// DMA traffic generator: issues read/write bursts of a deterministic word
// pattern over ctrl/chnl handshakes and counts read-back mismatches.
module axitrafficgen_rtl_dma_param
  import axitrafficgen_rtl_pkg::*;
#(
  parameter int          DMA_WIDTH = 32,
  parameter logic [31:0] WR_BASE   = 32'h0001_0000,
  parameter int          CNT_W     = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          conf_info_reg1,
  input  logic [31:0]          conf_info_reg2,
  input  logic                 conf_done,
  output logic                 acc_done,
  output logic [31:0]          debug,
  output logic                 dma_read_ctrl_valid,
  input  logic                 dma_read_ctrl_ready,
  output logic [31:0]          dma_read_ctrl_data_index,
  output logic [31:0]          dma_read_ctrl_data_length,
  output logic [2:0]           dma_read_ctrl_data_size,
  input  logic                 dma_read_chnl_valid,
  output logic                 dma_read_chnl_ready,
  input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
  output logic                 dma_write_ctrl_valid,
  input  logic                 dma_write_ctrl_ready,
  output logic [31:0]          dma_write_ctrl_data_index,
  output logic [31:0]          dma_write_ctrl_data_length,
  output logic [2:0]           dma_write_ctrl_data_size,
  output logic                 dma_write_chnl_valid,
  input  logic                 dma_write_chnl_ready,
  output logic [DMA_WIDTH-1:0] dma_write_chnl_data
);

  state_t           state, state_d;
  logic [31:0]      len_q, base_q, w_q;
  logic [1:0]       mode_q, conf_mode;
  logic [CNT_W-1:0] iter_q, i_q, i_nxt, conf_iter;
  logic             start, conf_zero, last_beat, rd_beat, wr_beat;
  logic             unused_conf;
  logic [DMA_WIDTH-1:0] exp_word;

  assign conf_mode   = conf_info_reg2[MODE_LSB +: MODE_W];
  assign conf_iter   = conf_info_reg2[ITER_LSB +: CNT_W];
  assign unused_conf = ^conf_info_reg2;
  assign start       = (state == S_IDLE) && conf_done;
  assign conf_zero   = (conf_mode == MODE_NOP) || (conf_info_reg1 == '0) || (conf_iter == '0);
  assign last_beat   = (w_q == len_q - 32'd1);
  assign rd_beat     = (state == S_RD_DATA) && dma_read_chnl_valid;
  assign wr_beat     = (state == S_WR_DATA) && dma_write_chnl_ready;
  assign i_nxt       = i_q + CNT_W'(1);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (conf_done) begin
                   if (conf_zero)              state_d = S_DONE;
                   else if (conf_mode == MODE_WR) state_d = S_WR_REQ;
                   else                        state_d = S_RD_REQ;
                 end
      S_RD_REQ:  if (dma_read_ctrl_ready) state_d = S_RD_DATA;
      S_RD_DATA: if (rd_beat && last_beat)
                   state_d = (mode_q == MODE_RDWR) ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  if (dma_write_ctrl_ready) state_d = S_WR_DATA;
      S_WR_DATA: if (wr_beat && last_beat) state_d = S_NEXT;
      S_NEXT:    if (i_nxt == iter_q)      state_d = S_DONE;
                 else if (mode_q == MODE_WR) state_d = S_WR_REQ;
                 else                      state_d = S_RD_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // config latch, iteration index, running burst base (i*len) and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q  <= '0;
      mode_q <= MODE_NOP;
      iter_q <= '0;
      i_q    <= '0;
      base_q <= '0;
      w_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (conf_done) begin
          len_q  <= conf_info_reg1;
          mode_q <= conf_mode;
          iter_q <= conf_iter;
          i_q    <= '0;
          base_q <= '0;
        end
        S_RD_REQ, S_WR_REQ: w_q <= '0;
        S_RD_DATA: if (rd_beat) w_q <= w_q + 32'd1;
        S_WR_DATA: if (wr_beat) w_q <= w_q + 32'd1;
        S_NEXT: begin
          i_q    <= i_nxt;
          base_q <= base_q + len_q;
        end
        default: ;
      endcase
    end
  end

  // completion pulse lands the cycle after DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_done <= 1'b0;
    else      acc_done <= (state == S_DONE);
  end

  // handshake and data outputs, zero outside their owning state
  always_comb begin
    dma_read_ctrl_valid        = 1'b0;
    dma_read_ctrl_data_index   = '0;
    dma_read_ctrl_data_length  = '0;
    dma_read_ctrl_data_size    = '0;
    dma_read_chnl_ready        = 1'b0;
    dma_write_ctrl_valid       = 1'b0;
    dma_write_ctrl_data_index  = '0;
    dma_write_ctrl_data_length = '0;
    dma_write_ctrl_data_size   = '0;
    dma_write_chnl_valid       = 1'b0;
    dma_write_chnl_data        = '0;
    case (state)
      S_RD_REQ: begin
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = base_q;
        dma_read_ctrl_data_length = len_q;
        dma_read_ctrl_data_size   = dma_size(DMA_WIDTH);
      end
      S_RD_DATA: dma_read_chnl_ready = 1'b1;
      S_WR_REQ: begin
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = WR_BASE + base_q;
        dma_write_ctrl_data_length = len_q;
        dma_write_ctrl_data_size   = dma_size(DMA_WIDTH);
      end
      S_WR_DATA: begin
        dma_write_chnl_valid = 1'b1;
        dma_write_chnl_data  = exp_word;
      end
      default: ;
    endcase
  end

  axitrafficgen_rtl_pattern #(.DMA_WIDTH(DMA_WIDTH)) u_pattern (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .chk_en   (rd_beat),
    .base     (base_q),
    .w        (w_q),
    .rd_data  (dma_read_chnl_data),
    .exp_word (exp_word),
    .mis_cnt  (debug)
  );

endmodule

// File: tb/tb_axitrafficgen_rtl_dma_param.sv
// Self-checking bench: memory/ready responder with random stalls, handshake
// logs, and a plain-arithmetic model of expected bursts and mismatches.
module tb_axitrafficgen_rtl_dma_param;
  localparam logic [31:0] WR_BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance
  logic [31:0] reg1 = '0, reg2 = '0;
  logic        conf_done = 1'b0, acc_done;
  logic [31:0] debug;
  logic        rcv, rcr = 1'b0, rdr, rdv = 1'b0;
  logic [31:0] rc_idx, rc_len, rd_data = '0;
  logic [2:0]  rc_size, wc_size;
  logic        wcv, wcr = 1'b0, wdv, wdr = 1'b0;
  logic [31:0] wc_idx, wc_len, wd_data;

  axitrafficgen_rtl_dma_param #(.DMA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .conf_info_reg1(reg1), .conf_info_reg2(reg2),
    .conf_done(conf_done), .acc_done(acc_done), .debug(debug),
    .dma_read_ctrl_valid(rcv), .dma_read_ctrl_ready(rcr),
    .dma_read_ctrl_data_index(rc_idx), .dma_read_ctrl_data_length(rc_len),
    .dma_read_ctrl_data_size(rc_size),
    .dma_read_chnl_valid(rdv), .dma_read_chnl_ready(rdr), .dma_read_chnl_data(rd_data),
    .dma_write_ctrl_valid(wcv), .dma_write_ctrl_ready(wcr),
    .dma_write_ctrl_data_index(wc_idx), .dma_write_ctrl_data_length(wc_len),
    .dma_write_ctrl_data_size(wc_size),
    .dma_write_chnl_valid(wdv), .dma_write_chnl_ready(wdr), .dma_write_chnl_data(wd_data)
  );

  // 64-bit instance, always-ready sinks
  logic [31:0] reg1_64 = '0, reg2_64 = '0, debug64;
  logic        cd64 = 1'b0, acc_done64;
  logic        rcv64, rcr64 = 1'b1, rdr64, rdv64 = 1'b0;
  logic [31:0] rc_idx64, rc_len64, wc_idx64, wc_len64;
  logic [2:0]  rc_size64, wc_size64;
  logic [63:0] rd_data64 = '0, wd_data64;
  logic        wcv64, wcr64 = 1'b1, wdv64, wdr64 = 1'b1;

  axitrafficgen_rtl_dma_param #(.DMA_WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .conf_info_reg1(reg1_64), .conf_info_reg2(reg2_64),
    .conf_done(cd64), .acc_done(acc_done64), .debug(debug64),
    .dma_read_ctrl_valid(rcv64), .dma_read_ctrl_ready(rcr64),
    .dma_read_ctrl_data_index(rc_idx64), .dma_read_ctrl_data_length(rc_len64),
    .dma_read_ctrl_data_size(rc_size64),
    .dma_read_chnl_valid(rdv64), .dma_read_chnl_ready(rdr64), .dma_read_chnl_data(rd_data64),
    .dma_write_ctrl_valid(wcv64), .dma_write_ctrl_ready(wcr64),
    .dma_write_ctrl_data_index(wc_idx64), .dma_write_ctrl_data_length(wc_len64),
    .dma_write_ctrl_data_size(wc_size64),
    .dma_write_chnl_valid(wdv64), .dma_write_chnl_ready(wdr64), .dma_write_chnl_data(wd_data64)
  );

  // environment state and logs
  int          stall = 0;
  int          corrupt_addr = -1;
  logic [31:0] rd_q[$];
  logic [31:0] log_rd_idx[$], log_rd_len[$], log_wr_idx[$], log_wr_len[$], log_wr_data[$];
  logic [2:0]  log_rd_size[$], log_wr_size[$];
  int          acc_cnt = 0, stab_err = 0, rd_beats = 0, cyc = 0, cd_cyc = 0, ad_cyc = 0;
  bit          ctrl_seen = 0;

  function automatic bit go();
    return $urandom_range(99) >= stall;
  endfunction

  // monitor at negedge (values seen by the next posedge), drive just after posedge
  initial begin : env
    bit          hs_rd, p_rcv, p_rcr, p_wcv, p_wcr, p_wdv, p_wdr;
    logic [31:0] p_ridx, p_rlen, p_widx, p_wlen, p_wd, addr;
    logic [2:0]  p_rsz, p_wsz;
    hs_rd = 0; p_rcv = 0; p_rcr = 0; p_wcv = 0; p_wcr = 0; p_wdv = 0; p_wdr = 0;
    p_ridx = 0; p_rlen = 0; p_widx = 0; p_wlen = 0; p_wd = 0; p_rsz = 0; p_wsz = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        hs_rd = 0; p_rcv = 0; p_wcv = 0; p_wdv = 0;
      end else begin
        if (conf_done) cd_cyc = cyc;
        if (acc_done) begin acc_cnt++; ad_cyc = cyc; end
        if (rcv || wcv) ctrl_seen = 1;
        if (p_rcv && !p_rcr && (!rcv || rc_idx !== p_ridx || rc_len !== p_rlen || rc_size !== p_rsz)) stab_err++;
        if (p_wcv && !p_wcr && (!wcv || wc_idx !== p_widx || wc_len !== p_wlen || wc_size !== p_wsz)) stab_err++;
        if (p_wdv && !p_wdr && (!wdv || wd_data !== p_wd)) stab_err++;
        if (rcv && rcr) begin
          log_rd_idx.push_back(rc_idx); log_rd_len.push_back(rc_len); log_rd_size.push_back(rc_size);
          for (int k = 0; k < int'(rc_len) && k < 1024; k++) begin
            addr = rc_idx + 32'(k);
            rd_q.push_back((corrupt_addr >= 0 && addr == 32'(corrupt_addr)) ? 32'hDEAD : addr);
          end
        end
        if (wcv && wcr) begin
          log_wr_idx.push_back(wc_idx); log_wr_len.push_back(wc_len); log_wr_size.push_back(wc_size);
        end
        hs_rd = rdv && rdr;
        if (hs_rd) rd_beats++;
        if (wdv && wdr) log_wr_data.push_back(wd_data);
        p_rcv = rcv; p_rcr = rcr; p_ridx = rc_idx; p_rlen = rc_len; p_rsz = rc_size;
        p_wcv = wcv; p_wcr = wcr; p_widx = wc_idx; p_wlen = wc_len; p_wsz = wc_size;
        p_wdv = wdv; p_wdr = wdr; p_wd = wd_data;
      end
      @(posedge clk); #1;
      if (!rst) begin
        rd_q.delete(); rcr = 0; wcr = 0; wdr = 0; rdv = 0; rd_data = 0;
      end else begin
        if (hs_rd && rd_q.size() > 0) void'(rd_q.pop_front());
        rcr = go(); wcr = go(); wdr = go();
        if (!(rdv && !hs_rd)) rdv = (rd_q.size() > 0) && go();
        rd_data = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
      end
    end
  end

  task automatic clear_logs();
    log_rd_idx.delete(); log_rd_len.delete(); log_rd_size.delete();
    log_wr_idx.delete(); log_wr_len.delete(); log_wr_size.delete(); log_wr_data.delete();
    acc_cnt = 0; stab_err = 0; rd_beats = 0; ctrl_seen = 0; cd_cyc = 0; ad_cyc = 0;
  endtask

  // pulse a configuration and wait (bounded) for completion
  task automatic run_cfg(input logic [1:0] m, input int l, input int it, output bit done);
    clear_logs();
    @(posedge clk); #1;
    reg1 = 32'(l);
    reg2 = (32'(it) << 8) | {24'h0, 6'($urandom), m};
    conf_done = 1;
    @(posedge clk); #1;
    conf_done = 0;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (acc_cnt > 0) done = 1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({rcv, rdr, wcv, wdv, acc_done} !== 5'b0) begin errors++;
      $display("FAIL reset_hs: got %b want 00000", {rcv, rdr, wcv, wdv, acc_done}); end
    checks++; if (debug !== 32'h0) begin errors++; $display("FAIL reset_debug: got %h want 0", debug); end
    checks++; if ({rc_idx, rc_len, wc_idx, wc_len, wd_data} !== 160'h0) begin errors++;
      $display("FAIL reset_data: rd_idx=%h wr_idx=%h wd=%h want 0", rc_idx, wc_idx, wd_data); end
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_write_only();
    bit done, bad;
    stall = 0; corrupt_addr = -1;
    run_cfg(2'd2, 4, 2, done);
    checks++; if (!done) begin errors++; $display("FAIL wo_done: no acc_done within bound"); end
    bad = (log_wr_idx.size() != 2);
    if (!bad) bad = (log_wr_idx[0] !== 32'h10000) || (log_wr_idx[1] !== 32'h10004) ||
                    (log_wr_len[0] !== 32'd4) || (log_wr_len[1] !== 32'd4) || (log_wr_size[0] !== 3'b010);
    checks++; if (bad) begin errors++;
      $display("FAIL wo_ctrl: got %0d reqs first=%h want 2 reqs 10000/10004 len 4 size 010",
               log_wr_idx.size(), (log_wr_idx.size() > 0) ? log_wr_idx[0] : 32'hx); end
    bad = (log_wr_data.size() != 8);
    if (!bad) foreach (log_wr_data[k]) if (log_wr_data[k] !== 32'(k)) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL wo_data: got %0d beats want 0..7 in order", log_wr_data.size()); end
    checks++; if (acc_cnt !== 1) begin errors++; $display("FAIL wo_acc: got %0d pulses want 1", acc_cnt); end
    checks++; if (debug !== 32'h0 || log_rd_idx.size() != 0) begin errors++;
      $display("FAIL wo_debug: debug=%h reads=%0d want 0/0", debug, log_rd_idx.size()); end
  endtask

  task automatic test_zero_wait();
    bit done; int l;
    stall = 0; corrupt_addr = -1;
    l = $urandom_range(6, 1);
    run_cfg(2'd2, l, 1, done);
    checks++; if (!done || ad_cyc - cd_cyc != l + 4) begin errors++;
      $display("FAIL zw_latency: len=%0d got %0d cycles want %0d", l, ad_cyc - cd_cyc, l + 4); end
  endtask

  task automatic test_read_corrupt();
    bit done;
    stall = 0; corrupt_addr = 5;
    run_cfg(2'd1, 8, 1, done);
    checks++; if (!done || log_rd_idx.size() != 1 || log_rd_idx[0] !== 32'h0 || log_rd_len[0] !== 32'd8 ||
                  log_rd_size[0] !== 3'b010) begin errors++;
      $display("FAIL rc_ctrl: done=%0d reqs=%0d want one req idx 0 len 8 size 010", done, log_rd_idx.size()); end
    checks++; if (debug !== 32'd1) begin errors++; $display("FAIL rc_debug: got %0d want 1", debug); end
    checks++; if (rd_beats != 8 || log_wr_idx.size() != 0) begin errors++;
      $display("FAIL rc_beats: beats=%0d writes=%0d want 8/0", rd_beats, log_wr_idx.size()); end
  endtask

  task automatic test_backpressure();
    bit done, bad;
    stall = 40; corrupt_addr = -1;
    run_cfg(2'd3, 3, 1, done);
    bad = !done || log_rd_idx.size() != 1 || log_wr_idx.size() != 1;
    if (!bad) bad = log_rd_idx[0] !== 32'h0 || log_rd_len[0] !== 32'd3 ||
                    log_wr_idx[0] !== 32'h10000 || log_wr_len[0] !== 32'd3;
    checks++; if (bad) begin errors++;
      $display("FAIL bp_ctrl: done=%0d rd_reqs=%0d wr_reqs=%0d want 1/1 idx 0,10000 len 3",
               done, log_rd_idx.size(), log_wr_idx.size()); end
    bad = (log_wr_data.size() != 3);
    if (!bad) foreach (log_wr_data[k]) if (log_wr_data[k] !== 32'(k)) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL bp_data: got %0d beats want 0,1,2", log_wr_data.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d stall changes want 0", stab_err); end
    checks++; if (rd_beats != 3 || debug !== 32'h0 || acc_cnt != 1) begin errors++;
      $display("FAIL bp_misc: beats=%0d debug=%0d acc=%0d want 3/0/1", rd_beats, debug, acc_cnt); end
    stall = 0;
  endtask

  task automatic test_degenerate();
    bit done;
    logic [1:0] ms[3]; int ls[3], its[3];
    ms = '{2'd0, 2'd1, 2'd3}; ls = '{4, 0, 4}; its = '{2, 2, 0};
    stall = 0;
    for (int n = 0; n < 3; n++) begin
      run_cfg(ms[n], ls[n], its[n], done);
      checks++; if (ctrl_seen) begin errors++; $display("FAIL degen%0d_ctrl: ctrl valid seen want none", n); end
      checks++; if (!done || ad_cyc - cd_cyc != 2 || acc_cnt != 1) begin errors++;
        $display("FAIL degen%0d_acc: latency=%0d pulses=%0d want 2/1", n, ad_cyc - cd_cyc, acc_cnt); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [1:0]  m;
      int          l, it, exp_dbg;
      logic [31:0] e_ridx[$], e_widx[$], e_wd[$];
      bit          done, bad;
      e_ridx.delete(); e_widx.delete(); e_wd.delete();
      m = 2'($urandom_range(3, 1)); l = $urandom_range(6, 1); it = $urandom_range(3, 1);
      stall = $urandom_range(50, 0);
      corrupt_addr = $urandom_range(1) ? int'($urandom_range(l * it - 1)) : -1;
      exp_dbg = 0;
      for (int i = 0; i < it; i++) begin
        if (m != 2'd2) begin
          e_ridx.push_back(32'(i * l));
          for (int k = 0; k < l; k++) if (i * l + k == corrupt_addr) exp_dbg++;
        end
        if (m != 2'd1) begin
          e_widx.push_back(WR_BASE + 32'(i * l));
          for (int k = 0; k < l; k++) e_wd.push_back(32'(i * l + k));
        end
      end
      run_cfg(m, l, it, done);
      checks++; if (!done || acc_cnt != 1) begin errors++;
        $display("FAIL rand%0d_acc: done=%0d pulses=%0d want 1/1", n, done, acc_cnt); end
      bad = log_rd_idx.size() != e_ridx.size();
      if (!bad) foreach (e_ridx[k]) if (log_rd_idx[k] !== e_ridx[k] || log_rd_len[k] !== 32'(l)) bad = 1;
      checks++; if (bad) begin errors++;
        $display("FAIL rand%0d_rd: m=%0d len=%0d it=%0d got %0d reqs want %0d", n, m, l, it, log_rd_idx.size(), e_ridx.size()); end
      bad = log_wr_idx.size() != e_widx.size();
      if (!bad) foreach (e_widx[k]) if (log_wr_idx[k] !== e_widx[k] || log_wr_len[k] !== 32'(l)) bad = 1;
      checks++; if (bad) begin errors++;
        $display("FAIL rand%0d_wr: m=%0d len=%0d it=%0d got %0d reqs want %0d", n, m, l, it, log_wr_idx.size(), e_widx.size()); end
      bad = log_wr_data.size() != e_wd.size();
      if (!bad) foreach (e_wd[k]) if (log_wr_data[k] !== e_wd[k]) bad = 1;
      checks++; if (bad) begin errors++;
        $display("FAIL rand%0d_wdata: got %0d beats want %0d", n, log_wr_data.size(), e_wd.size()); end
      checks++; if (debug !== 32'(exp_dbg) || stab_err != 0) begin errors++;
        $display("FAIL rand%0d_debug: debug=%0d stab=%0d want %0d/0", n, debug, stab_err, exp_dbg); end
    end
    stall = 0; corrupt_addr = -1;
  endtask

  task automatic test_mid_reset();
    bit done, hit;
    stall = 0; corrupt_addr = 0;
    clear_logs();
    @(posedge clk); #1;
    reg1 = 32'd8; reg2 = 32'h0000_0101; conf_done = 1;
    @(posedge clk); #1 conf_done = 0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (rd_beats >= 2) hit = 1;
    end
    @(posedge clk); #1;
    checks++; if (!hit || debug !== 32'd1) begin errors++;
      $display("FAIL mr_pre: reached=%0d debug=%0d want 1/1", hit, debug); end
    rst = 0; #1;
    checks++; if ({rcv, rdr, wcv, wdv, acc_done} !== 5'b0 || debug !== 32'h0 ||
                  {rc_idx, rc_len, wc_idx, wd_data} !== 128'h0) begin errors++;
      $display("FAIL mr_zero: hs=%b debug=%h want all 0", {rcv, rdr, wcv, wdv, acc_done}, debug); end
    repeat (3) @(posedge clk);
    checks++; if (acc_cnt != 0) begin errors++; $display("FAIL mr_partial: got %0d pulses want 0", acc_cnt); end
    #1 rst = 1;
    corrupt_addr = -1;
    run_cfg(2'd1, 8, 1, done);
    checks++; if (!done || log_rd_idx.size() != 1 || log_rd_idx[0] !== 32'h0 || rd_beats != 8) begin errors++;
      $display("FAIL mr_restart: done=%0d reqs=%0d beats=%0d want 1/1/8", done, log_rd_idx.size(), rd_beats); end
    checks++; if (debug !== 32'h0 || acc_cnt != 1) begin errors++;
      $display("FAIL mr_debug: debug=%0d acc=%0d want 0/1", debug, acc_cnt); end
  endtask

  task automatic test_dma64();
    logic [63:0] d[$];
    logic [2:0]  sz;
    logic [31:0] idx;
    bit          done;
    sz = 0; idx = 0; done = 0;
    @(posedge clk); #1;
    reg1_64 = 32'd2; reg2_64 = 32'h0000_0102; cd64 = 1;
    @(posedge clk); #1 cd64 = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (wcv64 && wcr64) begin sz = wc_size64; idx = wc_idx64; end
      if (wdv64 && wdr64) d.push_back(wd_data64);
      if (acc_done64) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL d64_done: no acc_done within bound"); end
    checks++; if (sz !== 3'b011 || idx !== 32'h10000) begin errors++;
      $display("FAIL d64_ctrl: size=%b idx=%h want 011/10000", sz, idx); end
    checks++; if (d.size() != 2 || d[0] !== 64'h0 || d[1] !== 64'h1) begin errors++;
      $display("FAIL d64_data: got %0d beats first=%h want 0,1", d.size(), (d.size() > 0) ? d[0] : 64'hx); end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_zero_wait();
    test_read_corrupt();
    test_backpressure();
    test_degenerate();
    test_random();
    test_mid_reset();
    test_dma64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
